i2c_reg_target: RTL and testbench
=================================

// Module: i2c_reg_target
// PURPOSE
//  Parametrised I2C target (slave) for a register bank. Adds bus-level register addressing:
//  a pointer byte, multi-byte bursts, pointer auto-increment and repeated START.
//  Sits between the board I2C pins (open-drain, via sda_oe) and a fabric-side register file.
//  No clock stretching; clock must be >= 16x SCL.
// PARAMETERS
//  I2C_ADDRESS  7'h49  7-bit target address
//  NUM_REGS     16     registers in the bank (2..256); pointer legal range 0..NUM_REGS-1
//  DATA_W       8      register width; must be 8 (one I2C byte per register)
//  SYNC_STAGES  2      synchroniser flops on scl_in/sda_in (>=2)
// PORTS
//  clock      in   1                system clock
//  reset      in   1                synchronous, active-high
//  scl_in     in   1                raw SCL pin
//  sda_in     in   1                raw SDA pin
//  sda_oe     out  1                1 = pull SDA low (open-drain); 0 = release
//  wr_valid   out  1                one-cycle pulse: write wr_data to reg[wr_addr]
//  wr_addr    out  $clog2(NUM_REGS) write register index
//  wr_data    out  DATA_W           write data
//  rd_addr    out  $clog2(NUM_REGS) read register index (= current pointer)
//  rd_data    in   DATA_W           reg[rd_addr], combinational from fabric
//  rd_strobe  out  1                one-cycle pulse when reg[rd_addr] is latched for sending
//  busy       out  1                1 from own-address match until STOP/non-match START
// BEHAVIOUR
//  - One clock `clock`; `reset` is synchronous and active-high. Reset: state=IDLE, pointer=0,
//    sda_oe=0, wr_valid=0, rd_strobe=0, busy=0, wr_addr=0, wr_data=0.
//  - Events from synchronised lines (one cycle each): scl_rise, scl_fall, START (SDA fall while
//    SCL high), STOP (SDA rise while SCL high). Bits sampled on scl_rise; target drives on scl_fall.
//  - START in ANY state (incl. mid-byte) -> ADDR, bit counter cleared (repeated START).
//    STOP in ANY state -> IDLE, sda_oe released same cycle. Pointer is kept across transactions.
//  - States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RD_MACK, IGNORE.
//  - ADDR: shift 8 bits MSB first. On 8th scl_fall: addr match -> ADDR_ACK, sda_oe=1, busy=1;
//    no match -> IGNORE (sda_oe stays 0 until next START/STOP).
//  - *_ACK states hold sda_oe=1 through the 9th SCL pulse; release on the 9th scl_fall.
//    ADDR_ACK exits: R/W=0 -> PTR; R/W=1 -> RDATA, with rd_data latched + rd_strobe pulsed
//    in that same cycle and MSB driven immediately.
//  - PTR: byte < NUM_REGS -> pointer<=byte, ACK, -> WDATA. byte >= NUM_REGS -> no ACK
//    (sda_oe=0), -> IGNORE, pointer unchanged.
//  - WDATA: on 8th scl_fall: wr_valid=1 for one cycle with wr_addr=pointer, wr_data=byte;
//    ACK; pointer <= (pointer==NUM_REGS-1) ? 0 : pointer+1; -> WDATA_ACK -> WDATA.
//  - RDATA: sda_oe = ~shift[7] on each scl_fall; after 8 bits release SDA -> RD_MACK;
//    pointer increments with wrap as above. RD_MACK samples master bit on scl_rise:
//    0 (ACK) -> latch next rd_data, pulse rd_strobe, -> RDATA; 1 (NACK) -> IGNORE.
//  - Partial byte cut by START/STOP: discarded, no wr_valid, pointer unchanged.
//  - SDA toggles while SCL low never count as START/STOP. Reset mid-transfer releases SDA at once.
// STRUCTURE
//  - i2c_pkg: state enum i2c_tgt_state_t, event struct i2c_evt_t {scl_rise, scl_fall, start,
//    stop, sda}, localparam I2C_BYTE_BITS=8.
//  - Sub-module i2c_bus_monitor: synchronisers + edge/START/STOP detection, outputs i2c_evt_t.
//  - Top: control FSM, 4-bit bit counter, 8-bit shift register, pointer register.
// TESTING
//  - Write burst: START,0x92,0x02,0xA5,0x3C,STOP -> 4 ACKs (incl. address); wr_valid
//    (2,0xA5) then (3,0x3C); pointer ends at 4.
//  - Read w/ repeated START: START,0x92,0x05,Sr,0x93, master ACK,ACK,NACK, STOP, fabric reg[n]=n+0x10 ->
//    bytes 0x15,0x16,0x17 on SDA; 3 rd_strobe pulses; pointer=8.
//  - Wrap: NUM_REGS=16, write ptr 0x0F, data 0x11,0x22 -> writes (15,0x11),(0,0x22).
//  - Wrong address 0xA0 / pointer 0x20 -> sda_oe never asserted after NACK point; no wr_valid;
//    busy=0 (wrong addr).
//  - Abort: STOP after 4 bits of data byte -> no wr_valid; IDLE; sda_oe=0; next transaction OK.
//  - Reset asserted during ACK bit -> sda_oe=0 next cycle, pointer=0, state IDLE.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types for the I2C register target: FSM states and per-cycle bus events.
package i2c_pkg;

   localparam int I2C_BYTE_BITS = 8;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ADDR_ACK,
      ST_PTR,
      ST_PTR_ACK,
      ST_WDATA,
      ST_WDATA_ACK,
      ST_RDATA,
      ST_RD_MACK,
      ST_IGNORE
   } i2c_tgt_state_t;

   typedef struct packed {
      logic scl_rise;
      logic scl_fall;
      logic start;
      logic stop;
      logic sda;
   } i2c_evt_t;

endpackage

// File: rtl/i2c_bus_monitor.sv
// Synchronises the raw SCL/SDA pins and reduces them to single-cycle bus events.
module i2c_bus_monitor
   import i2c_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic     clock,
   input  logic     reset,
   input  logic     scl_in,
   input  logic     sda_in,
   output i2c_evt_t evt
);

   // Top bit of each chain is the previous synchronised value; idle bus level is high.
   logic [SYNC_STAGES:0] scl_sh_q, scl_sh_d;
   logic [SYNC_STAGES:0] sda_sh_q, sda_sh_d;
   logic                 scl_cur, scl_prev, sda_cur, sda_prev;

   always_comb begin
      scl_sh_d = {scl_sh_q[SYNC_STAGES-1:0], scl_in};
      sda_sh_d = {sda_sh_q[SYNC_STAGES-1:0], sda_in};
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         scl_sh_q <= '1;
         sda_sh_q <= '1;
      end else begin
         scl_sh_q <= scl_sh_d;
         sda_sh_q <= sda_sh_d;
      end
   end

   assign scl_cur  = scl_sh_q[SYNC_STAGES-1];
   assign scl_prev = scl_sh_q[SYNC_STAGES];
   assign sda_cur  = sda_sh_q[SYNC_STAGES-1];
   assign sda_prev = sda_sh_q[SYNC_STAGES];

   always_comb begin
      evt.scl_rise = scl_cur & ~scl_prev;
      evt.scl_fall = ~scl_cur & scl_prev;
      evt.start    = scl_cur & scl_prev & sda_prev & ~sda_cur;
      evt.stop     = scl_cur & scl_prev & ~sda_prev & sda_cur;
      evt.sda      = sda_cur;
   end

endmodule

// File: rtl/i2c_reg_target.sv
// I2C target exposing a register bank: pointer byte, auto-incrementing bursts, repeated START.
module i2c_reg_target
   import i2c_pkg::*;
#(
   parameter logic [6:0] I2C_ADDRESS = 7'h49,
   parameter int         NUM_REGS    = 16,
   parameter int         DATA_W      = 8,
   parameter int         SYNC_STAGES = 2,
   localparam int        PTR_W       = $clog2(NUM_REGS)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              scl_in,
   input  logic              sda_in,
   output logic              sda_oe,
   output logic              wr_valid,
   output logic [PTR_W-1:0]  wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic [PTR_W-1:0]  rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   output logic              rd_strobe,
   output logic              busy
);

   localparam logic [3:0] BYTE_CNT = 4'(I2C_BYTE_BITS);

   i2c_evt_t evt;

   i2c_tgt_state_t    state_q, state_d;
   logic [3:0]        bit_cnt_q, bit_cnt_d;
   logic [7:0]        shift_q, shift_d;
   logic [PTR_W-1:0]  ptr_q, ptr_d;
   logic              rw_q, rw_d;
   logic              sda_oe_q, sda_oe_d;
   logic              wr_valid_q, wr_valid_d;
   logic [PTR_W-1:0]  wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;
   logic              rd_strobe_q, rd_strobe_d;
   logic              busy_q, busy_d;
   logic              byte_done;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(NUM_REGS - 1)) ? '0 : p + 1'b1;
   endfunction

   i2c_bus_monitor #(.SYNC_STAGES(SYNC_STAGES)) u_mon (
      .clock  (clock),
      .reset  (reset),
      .scl_in (scl_in),
      .sda_in (sda_in),
      .evt    (evt)
   );

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      ptr_d       = ptr_q;
      rw_d        = rw_q;
      sda_oe_d    = sda_oe_q;
      wr_valid_d  = 1'b0;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      rd_strobe_d = 1'b0;
      busy_d      = busy_q;
      byte_done   = evt.scl_fall && (bit_cnt_q == BYTE_CNT);

      // STOP and START override whatever byte is in flight; a partial byte is simply dropped.
      if (evt.stop) begin
         state_d   = ST_IDLE;
         sda_oe_d  = 1'b0;
         busy_d    = 1'b0;
         bit_cnt_d = '0;
      end else if (evt.start) begin
         state_d   = ST_ADDR;
         sda_oe_d  = 1'b0;
         bit_cnt_d = '0;
      end else begin
         case (state_q)
            ST_ADDR, ST_PTR, ST_WDATA: begin
               if (evt.scl_rise) begin
                  shift_d   = {shift_q[6:0], evt.sda};
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end else if (byte_done) begin
                  bit_cnt_d = '0;
                  if (state_q == ST_ADDR) begin
                     if (shift_q[7:1] == I2C_ADDRESS) begin
                        state_d  = ST_ADDR_ACK;
                        sda_oe_d = 1'b1;
                        busy_d   = 1'b1;
                        rw_d     = shift_q[0];
                     end else begin
                        state_d = ST_IGNORE;
                        busy_d  = 1'b0;
                     end
                  end else if (state_q == ST_PTR) begin
                     if (int'(shift_q) < NUM_REGS) begin
                        state_d  = ST_PTR_ACK;
                        ptr_d    = shift_q[PTR_W-1:0];
                        sda_oe_d = 1'b1;
                     end else begin
                        state_d = ST_IGNORE;
                     end
                  end else begin
                     state_d    = ST_WDATA_ACK;
                     wr_valid_d = 1'b1;
                     wr_addr_d  = ptr_q;
                     wr_data_d  = DATA_W'(shift_q);
                     ptr_d      = next_ptr(ptr_q);
                     sda_oe_d   = 1'b1;
                  end
               end
            end
            ST_ADDR_ACK: begin
               if (evt.scl_fall) begin
                  bit_cnt_d = '0;
                  if (rw_q) begin
                     state_d     = ST_RDATA;
                     shift_d     = 8'(rd_data);
                     rd_strobe_d = 1'b1;
                     sda_oe_d    = ~rd_data[I2C_BYTE_BITS-1];
                  end else begin
                     state_d  = ST_PTR;
                     sda_oe_d = 1'b0;
                  end
               end
            end
            ST_PTR_ACK, ST_WDATA_ACK: begin
               if (evt.scl_fall) begin
                  state_d   = ST_WDATA;
                  sda_oe_d  = 1'b0;
                  bit_cnt_d = '0;
               end
            end
            ST_RDATA: begin
               if (evt.scl_rise) begin
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end else if (evt.scl_fall) begin
                  // Count 0 means the byte was just reloaded after a master ACK: drive its MSB.
                  if (bit_cnt_q == 4'd0) begin
                     sda_oe_d = ~shift_q[7];
                  end else if (bit_cnt_q == BYTE_CNT) begin
                     state_d   = ST_RD_MACK;
                     sda_oe_d  = 1'b0;
                     ptr_d     = next_ptr(ptr_q);
                     bit_cnt_d = '0;
                  end else begin
                     shift_d  = {shift_q[6:0], 1'b0};
                     sda_oe_d = ~shift_q[6];
                  end
               end
            end
            ST_RD_MACK: begin
               if (evt.scl_rise) begin
                  if (!evt.sda) begin
                     state_d     = ST_RDATA;
                     shift_d     = 8'(rd_data);
                     rd_strobe_d = 1'b1;
                     bit_cnt_d   = '0;
                  end else begin
                     state_d = ST_IGNORE;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         bit_cnt_q   <= '0;
         ptr_q       <= '0;
         sda_oe_q    <= 1'b0;
         wr_valid_q  <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         rd_strobe_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         ptr_q       <= ptr_d;
         sda_oe_q    <= sda_oe_d;
         wr_valid_q  <= wr_valid_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         rd_strobe_q <= rd_strobe_d;
         busy_q      <= busy_d;
      end
   end

   always_ff @(posedge clock) begin
      shift_q <= shift_d;
      rw_q    <= rw_d;
   end

   assign sda_oe    = sda_oe_q;
   assign wr_valid  = wr_valid_q;
   assign wr_addr   = wr_addr_q;
   assign wr_data   = wr_data_q;
   assign rd_addr   = ptr_q;
   assign rd_strobe = rd_strobe_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_reg_target.sv
// Bench for i2c_reg_target: a bit-banged I2C master plus a register-bank model on the fabric side.
module tb_i2c_reg_target;

   localparam int NUM = 16;
   localparam int Q   = 8;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       scl_m = 1'b1;
   logic       sda_m = 1'b1;
   logic       sda_line;
   logic       sda_oe, wr_valid, rd_strobe, busy;
   logic [3:0] wr_addr, rd_addr;
   logic [7:0] wr_data, rd_data;

   logic [7:0] fab_mem [NUM];
   logic [3:0] wr_log_a [256];
   logic [7:0] wr_log_d [256];
   int         wr_cnt = 0;
   int         rs_cnt = 0;
   int         oe_cnt = 0;

   logic [7:0] ref_mem [NUM];
   logic [7:0] wbuf [8];
   int         mptr;
   int         n_checks = 0;
   int         n_err = 0;

   i2c_reg_target #(
      .I2C_ADDRESS (7'h49),
      .NUM_REGS    (NUM),
      .DATA_W      (8),
      .SYNC_STAGES (2)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .scl_in    (scl_m),
      .sda_in    (sda_line),
      .sda_oe    (sda_oe),
      .wr_valid  (wr_valid),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .rd_strobe (rd_strobe),
      .busy      (busy)
   );

   always #5 clock = ~clock;

   // Open-drain bus: either side may pull low.
   assign sda_line = sda_m & ~sda_oe;
   assign rd_data  = fab_mem[rd_addr];

   always @(posedge clock) begin
      if (reset) begin
         for (int n = 0; n < NUM; n++) fab_mem[n] <= 8'(n + 16);
      end else if (wr_valid) begin
         fab_mem[wr_addr] <= wr_data;
      end
   end

   always @(posedge clock) begin
      if (wr_valid) begin
         wr_log_a[wr_cnt[7:0]] <= wr_addr;
         wr_log_d[wr_cnt[7:0]] <= wr_data;
         wr_cnt <= wr_cnt + 1;
      end
      if (rd_strobe) rs_cnt <= rs_cnt + 1;
      if (sda_oe) oe_cnt <= oe_cnt + 1;
   end

   initial begin
      repeat (200000) @(posedge clock);
      $display("FAIL watchdog: observed=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_q();
      repeat (Q) @(negedge clock);
   endtask

   task automatic bus_start();
      sda_m = 1'b1; wait_q();
      scl_m = 1'b1; wait_q();
      sda_m = 1'b0; wait_q();
      scl_m = 1'b0; wait_q();
   endtask

   task automatic bus_stop();
      sda_m = 1'b0; wait_q();
      scl_m = 1'b1; wait_q();
      sda_m = 1'b1; wait_q();
      wait_q();
   endtask

   task automatic send_bit(input logic b);
      sda_m = b;    wait_q();
      scl_m = 1'b1; wait_q(); wait_q();
      scl_m = 1'b0; wait_q();
   endtask

   task automatic recv_bit(output logic b);
      sda_m = 1'b1; wait_q();
      scl_m = 1'b1; wait_q();
      b = sda_line; wait_q();
      scl_m = 1'b0; wait_q();
   endtask

   task automatic write_byte(input logic [7:0] v, output logic ack);
      logic b;
      for (int i = 7; i >= 0; i--) send_bit(v[i]);
      recv_bit(b);
      ack = ~b;
   endtask

   task automatic read_byte(input logic ack, output logic [7:0] v);
      logic b;
      for (int i = 7; i >= 0; i--) begin
         recv_bit(b);
         v[i] = b;
      end
      send_bit(~ack);
   endtask

   task automatic model_reset();
      for (int n = 0; n < NUM; n++) ref_mem[n] = 8'(n + 16);
      mptr = 0;
   endtask

   // Write burst of n bytes from wbuf starting at register p.
   task automatic do_write(input string tag, input int p, input int n);
      logic ack;
      int   base, idx;
      base = wr_cnt;
      bus_start();
      write_byte(8'h92, ack);
      chk({tag, "_addr_ack"}, 32'(ack), 32'd1);
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      write_byte(8'(p), ack);
      chk({tag, "_ptr_ack"}, 32'(ack), 32'd1);
      for (int k = 0; k < n; k++) begin
         write_byte(wbuf[k], ack);
         chk({tag, "_data_ack"}, 32'(ack), 32'd1);
      end
      bus_stop();
      chk({tag, "_nwrites"}, 32'(wr_cnt - base), 32'(n));
      for (int k = 0; k < n; k++) begin
         idx = (p + k) % NUM;
         chk({tag, "_wr_addr"}, 32'(wr_log_a[8'(base + k)]), 32'(idx));
         chk({tag, "_wr_data"}, 32'(wr_log_d[8'(base + k)]), 32'(wbuf[k]));
         ref_mem[idx] = wbuf[k];
      end
      mptr = (p + n) % NUM;
      chk({tag, "_ptr"}, 32'(rd_addr), 32'(mptr));
      chk({tag, "_busy_end"}, 32'(busy), 32'd0);
   endtask

   // Set pointer p, repeated START, then read n bytes (ACK all but the last).
   task automatic do_read(input string tag, input int p, input int n);
      logic       ack;
      logic [7:0] v;
      int         base;
      base = rs_cnt;
      bus_start();
      write_byte(8'h92, ack);
      chk({tag, "_addr_ack"}, 32'(ack), 32'd1);
      write_byte(8'(p), ack);
      chk({tag, "_ptr_ack"}, 32'(ack), 32'd1);
      bus_start();
      write_byte(8'h93, ack);
      chk({tag, "_raddr_ack"}, 32'(ack), 32'd1);
      for (int k = 0; k < n; k++) begin
         read_byte(k < n - 1, v);
         chk({tag, "_rdata"}, 32'(v), 32'(ref_mem[(p + k) % NUM]));
      end
      bus_stop();
      chk({tag, "_strobes"}, 32'(rs_cnt - base), 32'(n));
      mptr = (p + n) % NUM;
      chk({tag, "_ptr"}, 32'(rd_addr), 32'(mptr));
   endtask

   initial begin
      logic ack;
      int   base, oe_base, p, n;
      model_reset();
      repeat (4) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      chk("rst_sda_oe", 32'(sda_oe), 32'd0);
      chk("rst_wr_valid", 32'(wr_valid), 32'd0);
      chk("rst_rd_strobe", 32'(rd_strobe), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_wr_addr", 32'(wr_addr), 32'd0);
      chk("rst_wr_data", 32'(wr_data), 32'd0);
      chk("rst_ptr", 32'(rd_addr), 32'd0);
      repeat (4) @(negedge clock);

      wbuf[0] = 8'hA5; wbuf[1] = 8'h3C;
      do_write("burst", 2, 2);
      do_read("rdsr", 5, 3);
      wbuf[0] = 8'h11; wbuf[1] = 8'h22;
      do_write("wrap", 15, 2);

      // Wrong target address: never acknowledged, never driven, not busy.
      base = wr_cnt; oe_base = oe_cnt;
      bus_start();
      write_byte(8'hA0, ack);
      chk("badaddr_ack", 32'(ack), 32'd0);
      chk("badaddr_busy", 32'(busy), 32'd0);
      write_byte(8'h01, ack);
      chk("badaddr_data_ack", 32'(ack), 32'd0);
      bus_stop();
      chk("badaddr_oe", 32'(oe_cnt - oe_base), 32'd0);
      chk("badaddr_nwr", 32'(wr_cnt - base), 32'd0);

      // Out-of-range pointer: NACKed, pointer kept, later data ignored.
      bus_start();
      write_byte(8'h92, ack);
      chk("badptr_addr_ack", 32'(ack), 32'd1);
      oe_base = oe_cnt;
      write_byte(8'h20, ack);
      chk("badptr_ack", 32'(ack), 32'd0);
      write_byte(8'h55, ack);
      chk("badptr_data_ack", 32'(ack), 32'd0);
      chk("badptr_oe", 32'(oe_cnt - oe_base), 32'd0);
      bus_stop();
      chk("badptr_nwr", 32'(wr_cnt - base), 32'd0);
      chk("badptr_ptr", 32'(rd_addr), 32'(mptr));

      // STOP after half a data byte: nothing written, target idle, bus released.
      bus_start();
      write_byte(8'h92, ack);
      chk("abort_addr_ack", 32'(ack), 32'd1);
      write_byte(8'h07, ack);
      chk("abort_ptr_ack", 32'(ack), 32'd1);
      mptr = 7;
      for (int i = 0; i < 4; i++) send_bit(1'(i & 1));
      bus_stop();
      chk("abort_nwr", 32'(wr_cnt - base), 32'd0);
      chk("abort_sda_oe", 32'(sda_oe), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_ptr", 32'(rd_addr), 32'(mptr));
      wbuf[0] = 8'h5A;
      do_write("after_abort", 7, 1);

      // Reset while the target is holding the address ACK.
      bus_start();
      for (int i = 7; i >= 0; i--) send_bit(1'(8'h92 >> i));
      sda_m = 1'b1; wait_q();
      scl_m = 1'b1; wait_q();
      chk("rstack_driving", 32'(sda_oe), 32'd1);
      reset = 1'b1;
      @(posedge clock);
      @(negedge clock);
      chk("rstack_sda_oe", 32'(sda_oe), 32'd0);
      chk("rstack_ptr", 32'(rd_addr), 32'd0);
      chk("rstack_busy", 32'(busy), 32'd0);
      reset = 1'b0;
      model_reset();
      scl_m = 1'b0; wait_q();
      bus_stop();
      do_read("after_rst", 3, 2);

      for (int it = 0; it < 5; it++) begin
         p = int'($urandom_range(0, NUM - 1));
         n = int'($urandom_range(1, 4));
         for (int k = 0; k < n; k++) wbuf[k] = 8'($urandom);
         do_write("rnd_wr", p, n);
         p = int'($urandom_range(0, NUM - 1));
         n = int'($urandom_range(1, 4));
         do_read("rnd_rd", p, n);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
